// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bundle for load_store_unit.
// slave  : the load/store unit side.
// master : the execute-stage / memory side that drives requests and mem_rdata.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_write;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_wdata, mem_write
   );

   modport master (
      output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_wdata, mem_write
   );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: sequential bridge from the execute stage to a big-endian,
// byte-addressed data memory with a 32-bit word port. One request in flight;
// sub-word stores use read-modify-write, loads are sign/zero-extended.
// Optional: define LSU_FAULT_EN to flag misaligned and out-of-range requests.
module load_store_unit #(
   parameter int unsigned MEMORY_SIZE = 16
) (
   input  logic             clk,
   input  logic             rst,
   load_store_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WRITE, RESP} state_t;

   localparam logic [31:0] LAST_WORD = 32'(MEMORY_SIZE - 4);

   state_t      state_q, state_d;
   logic        store_q, unsigned_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q, wdata_q, merge_q;
   logic [31:0] resp_rdata_q;
   logic        resp_fault_q;

   logic        accept, req_fault, wr_state;
   logic [1:0]  off;
   logic [31:0] wa, req_wa, load_val, merge_val;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   assign accept = bus.req_valid && (state_q == IDLE);
   assign req_wa = {bus.req_addr[31:2], 2'b00};
   assign wa     = {addr_q[31:2], 2'b00};

`ifdef LSU_FAULT_EN
   // Classify the incoming request as misaligned or beyond the last word.
   always_comb begin
      req_fault = 1'b0;
      if (bus.req_size == 2'd1 && bus.req_addr[0])              req_fault = 1'b1;
      if (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00))      req_fault = 1'b1;
      if (req_wa > LAST_WORD)                                   req_fault = 1'b1;
   end
`else
   logic unused_range;
   assign req_fault    = 1'b0;
   assign unused_range = (req_wa > LAST_WORD);
`endif

   // Effective lane offset; misaligned halfwords/words are forced onto their
   // natural lane (only reachable when faulting is disabled).
   always_comb begin
      if (size_q[1])            off = 2'b00;
      else if (size_q == 2'd1)  off = {addr_q[1], 1'b0};
      else                      off = addr_q[1:0];
   end

   // Lane extraction, extension and store-lane merge against mem_rdata.
   always_comb begin
      lane_b    = bus.mem_rdata[31 - 8*off -: 8];
      lane_h    = off[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
      load_val  = bus.mem_rdata;
      merge_val = wdata_q;
      if (size_q == 2'd0) begin
         load_val  = unsigned_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
         merge_val = bus.mem_rdata;
         merge_val[31 - 8*off -: 8] = wdata_q[7:0];
      end else if (size_q == 2'd1) begin
         load_val  = unsigned_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
         merge_val = off[1] ? {bus.mem_rdata[31:16], wdata_q[15:0]}
                            : {wdata_q[15:0], bus.mem_rdata[15:0]};
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:        if (accept) state_d = req_fault ? RESP : ACCESS;
         ACCESS:      state_d = (store_q && !size_q[1]) ? MERGE_WRITE : RESP;
         MERGE_WRITE: state_d = RESP;
         RESP:        state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   // Request capture, merge word, and response registers (loaded on entry to RESP).
   always_ff @(posedge clk) begin
      if (rst) begin
         store_q      <= 1'b0;
         unsigned_q   <= 1'b0;
         size_q       <= 2'd0;
         addr_q       <= '0;
         wdata_q      <= '0;
         merge_q      <= '0;
         resp_rdata_q <= '0;
         resp_fault_q <= 1'b0;
      end else begin
         if (accept) begin
            store_q    <= bus.req_store;
            unsigned_q <= bus.req_unsigned;
            size_q     <= bus.req_size;
            addr_q     <= bus.req_addr;
            wdata_q    <= bus.req_wdata;
         end
         if (state_q == ACCESS) merge_q <= merge_val;
         if (state_d == RESP && state_q != RESP) begin
            resp_fault_q <= (state_q == IDLE);
            resp_rdata_q <= (state_q == ACCESS && !store_q) ? load_val : '0;
         end
      end
   end

   // Output decode.
   always_comb begin
      wr_state       = (state_q == ACCESS && store_q && size_q[1]) || (state_q == MERGE_WRITE);
      bus.req_ready  = (state_q == IDLE);
      bus.resp_valid = (state_q == RESP);
      bus.resp_rdata = resp_rdata_q;
      bus.resp_fault = resp_fault_q;
      bus.mem_addr   = (state_q == ACCESS || state_q == MERGE_WRITE) ? wa : '0;
      bus.mem_wdata  = '0;
      if (state_q == ACCESS && store_q && size_q[1]) bus.mem_wdata = wdata_q;
      else if (state_q == MERGE_WRITE)               bus.mem_wdata = merge_q;
      bus.mem_write  = wr_state && !rst;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected responses and
// memory writes (with their cycle) into queues; a negedge monitor pops and compares.
module tb_load_store_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   load_store_unit_if bus();

   load_store_unit #(.MEMORY_SIZE(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // 16-byte data memory, combinational read, out-of-range reads return 0.
   logic [31:0] mem [4];
   assign bus.mem_rdata = (bus.mem_addr < 32'd16) ? mem[bus.mem_addr[3:2]] : '0;
   always @(posedge clk) begin
      if (cyc == 0) begin
         mem[0] <= 32'h8899AABB;
         mem[1] <= '0;
         mem[2] <= '0;
         mem[3] <= '0;
      end else if (bus.mem_write && bus.mem_addr < 32'd16) begin
         mem[bus.mem_addr[3:2]] <= bus.mem_wdata;
      end
   end

   typedef struct {logic [31:0] rdata; logic fault; int at;} resp_t;
   typedef struct {logic [31:0] addr; logic [31:0] data; int at;} wr_t;
   resp_t rq[$];
   wr_t   wq[$];

   int checks = 0;
   int failures = 0;

   // Monitor: every response pulse and memory write must match the queue head.
   always @(negedge clk) begin
      resp_t er;
      wr_t   ew;
      if (bus.resp_valid) begin
         checks++;
         if (rq.size() == 0) begin
            failures++;
            $display("FAIL resp_unexpected cyc=%0d rdata=%h fault=%b", cyc, bus.resp_rdata, bus.resp_fault);
         end else begin
            er = rq.pop_front();
            if (bus.resp_rdata !== er.rdata || bus.resp_fault !== er.fault || cyc != er.at) begin
               failures++;
               $display("FAIL resp got rdata=%h fault=%b cyc=%0d expected rdata=%h fault=%b cyc=%0d",
                        bus.resp_rdata, bus.resp_fault, cyc, er.rdata, er.fault, er.at);
            end
         end
      end
      if (bus.mem_write) begin
         checks++;
         if (wq.size() == 0) begin
            failures++;
            $display("FAIL write_unexpected cyc=%0d addr=%h data=%h", cyc, bus.mem_addr, bus.mem_wdata);
         end else begin
            ew = wq.pop_front();
            if (bus.mem_addr !== ew.addr || bus.mem_wdata !== ew.data || cyc != ew.at) begin
               failures++;
               $display("FAIL write got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                        bus.mem_addr, bus.mem_wdata, cyc, ew.addr, ew.data, ew.at);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   // Present a request at a negedge and wait (bounded) for its accepting edge.
   // acc = IDLE cycle of acceptance; waits = negedges spent with req_ready low.
   task automatic issue(input logic st, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd, input bit hold,
                        output int acc, output int waits);
      @(negedge clk);
      bus.req_store    = st;
      bus.req_size     = sz;
      bus.req_unsigned = un;
      bus.req_addr     = a;
      bus.req_wdata    = wd;
      bus.req_valid    = 1'b1;
      waits = 0;
      while (!bus.req_ready && waits < 20) begin
         waits++;
         @(negedge clk);
      end
      if (!bus.req_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout addr=%h", a);
         bus.req_valid = 1'b0;
         acc = -100;
      end else begin
         acc = cyc;
         @(posedge clk);
         #1;
         if (!hold) bus.req_valid = 1'b0;
      end
   endtask

   task automatic load(input logic [1:0] sz, input logic un, input logic [31:0] a, input logic [31:0] exp);
      int acc, w;
      issue(1'b0, sz, un, a, '0, 1'b0, acc, w);
      rq.push_back('{exp, 1'b0, acc + 2});
   endtask

   // Word stores write at N+1 and respond at N+2; sub-word at N+2 / N+3.
   task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_word);
      int acc, w, wl;
      issue(1'b1, sz, 1'b0, a, wd, 1'b0, acc, w);
      wl = sz[1] ? 1 : 2;
      wq.push_back('{{a[31:2], 2'b00}, exp_word, acc + wl});
      rq.push_back('{32'h0, 1'b0, acc + wl + 1});
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && (rq.size() != 0 || wq.size() != 0); i++) @(negedge clk);
      @(posedge clk);
      checks++;
      if (rq.size() != 0 || wq.size() != 0) begin
         failures++;
         $display("FAIL drain pending resp=%0d writes=%0d expected 0", rq.size(), wq.size());
         rq.delete();
         wq.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int acc0, acc1, acc2, w0, w1, w2;
      bus.req_valid    = 1'b0;
      bus.req_store    = 1'b0;
      bus.req_size     = 2'd0;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = '0;
      bus.req_wdata    = '0;

      repeat (3) @(negedge clk);
      check("rst_req_ready",  32'(bus.req_ready),  32'd1);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_resp_rdata", bus.resp_rdata,      32'h0);
      check("rst_resp_fault", 32'(bus.resp_fault), 32'd0);
      check("rst_mem_addr",   bus.mem_addr,        32'h0);
      check("rst_mem_wdata",  bus.mem_wdata,       32'h0);
      check("rst_mem_write",  32'(bus.mem_write),  32'd0);
      rst = 1'b0;

      load(2'd0, 1'b0, 32'd1, 32'hFFFFFF99);
      load(2'd0, 1'b1, 32'd1, 32'h00000099);
      load(2'd1, 1'b1, 32'd2, 32'h0000AABB);
      load(2'd2, 1'b0, 32'd0, 32'h8899AABB);
      store(2'd0, 32'd2, 32'h123456CC, 32'h8899CCBB);
      load(2'd2, 1'b0, 32'd0, 32'h8899CCBB);
      store(2'd2, 32'd4, 32'hDEADBEEF, 32'hDEADBEEF);
      load(2'd1, 1'b0, 32'd6, 32'hFFFFBEEF);
      store(2'd1, 32'd0, 32'h00001234, 32'h1234CCBB);
      load(2'd0, 1'b1, 32'd3, 32'h000000BB);
      load(2'd1, 1'b0, 32'd0, 32'h00001234);
      store(2'd0, 32'd7, 32'h0000005A, 32'hDEADBE5A);
      load(2'd3, 1'b0, 32'd4, 32'hDEADBE5A);
      drain();

`ifdef LSU_FAULT_EN
      issue(1'b0, 2'd1, 1'b0, 32'd1, '0, 1'b0, acc0, w0);
      rq.push_back('{32'h0, 1'b1, acc0 + 1});
      issue(1'b1, 2'd2, 1'b0, 32'd16, 32'hCAFEF00D, 1'b0, acc0, w0);
      rq.push_back('{32'h0, 1'b1, acc0 + 1});
      drain();
      check("fault_mem0", mem[0], 32'h1234CCBB);
      check("fault_mem1", mem[1], 32'hDEADBE5A);
      load(2'd2, 1'b0, 32'd4, 32'hDEADBE5A);
`else
      load(2'd1, 1'b0, 32'd7, 32'hFFFFBE5A);
      load(2'd2, 1'b0, 32'd16, 32'h00000000);
`endif
      drain();

      // Back-to-back loads with req_valid held across the busy periods.
      issue(1'b0, 2'd2, 1'b0, 32'd0, '0, 1'b1, acc0, w0);
      rq.push_back('{32'h1234CCBB, 1'b0, acc0 + 2});
      issue(1'b0, 2'd2, 1'b0, 32'd4, '0, 1'b1, acc1, w1);
      rq.push_back('{32'hDEADBE5A, 1'b0, acc1 + 2});
      issue(1'b0, 2'd0, 1'b1, 32'd3, '0, 1'b0, acc2, w2);
      rq.push_back('{32'h000000BB, 1'b0, acc2 + 2});
      check("b2b_gap1",  32'(acc1 - acc0), 32'd3);
      check("b2b_gap2",  32'(acc2 - acc1), 32'd3);
      check("b2b_busy1", 32'(w1), 32'd2);
      check("b2b_busy2", 32'(w2), 32'd2);
      drain();

      // Reset during MERGE_WRITE of a byte store: no write, no response.
      issue(1'b1, 2'd0, 1'b0, 32'd1, 32'h000000FF, 1'b0, acc0, w0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rst_merge_mem_write", 32'(bus.mem_write), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("rst_merge_ready",      32'(bus.req_ready),  32'd1);
      check("rst_merge_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_merge_resp_rdata", bus.resp_rdata,      32'h0);
      repeat (4) @(negedge clk);
      check("rst_merge_mem0", mem[0], 32'h1234CCBB);
      load(2'd2, 1'b0, 32'd0, 32'h1234CCBB);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
